// File: rtl/request_unit.sv
// request_unit: sequences instruction fetch and data access toward the cache,
// returns hits and PC-advance strobe, counts stall cycles and flags stuck requests.
module request_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_word_en,
    input  logic             i_store_word_en,
    input  logic             i_halt,
    input  logic             i_cache_ihit,
    input  logic             i_cache_dhit,
    output logic             o_imemREN,
    output logic             o_dmemREN,
    output logic             o_dmemWEN,
    output logic             o_ihit,
    output logic             o_dhit,
    output logic             o_pc_en,
    output logic             o_halted,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_stall_cycles
);
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_HALT} state_t;
    state_t          r_state;
    logic            r_op_ld;
    logic            r_op_st;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_timeout;
    logic [CNT_W-1:0] r_stall;
    logic            w_fetch;
    logic            w_data;
    logic            w_busy;
    logic            w_hit;
    logic            w_mem_op;
    assign w_fetch        = (r_state == S_FETCH);
    assign w_data         = (r_state == S_DATA);
    assign w_busy         = w_fetch | w_data;
    assign o_ihit         = w_fetch & i_cache_ihit;
    assign o_dhit         = w_data & i_cache_dhit;
    assign w_hit          = o_ihit | o_dhit;
    assign w_mem_op       = i_load_word_en | i_store_word_en;
    assign o_imemREN      = w_fetch;
    assign o_dmemREN      = w_data & r_op_ld;
    assign o_dmemWEN      = w_data & r_op_st;
    assign o_halted       = (r_state == S_HALT);
    // ALU instructions retire on the ihit cycle, memory instructions on the dhit cycle.
    assign o_pc_en        = (o_ihit & ~i_halt & ~w_mem_op) | o_dhit;
    assign o_timeout      = r_timeout;
    assign o_stall_cycles = r_stall;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op_ld    <= 1'b0;
            r_op_st    <= 1'b0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_stall    <= '0;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= S_FETCH;
                S_FETCH: if (i_cache_ihit) begin
                    if (i_halt) r_state <= S_HALT;
                    else if (w_mem_op) begin
                        r_state <= S_DATA;
                        r_op_ld <= i_load_word_en;
                        r_op_st <= i_store_word_en & ~i_load_word_en;
                    end
                end
                S_DATA:  if (i_cache_dhit) begin
                    r_state <= S_FETCH;
                    r_op_ld <= 1'b0;
                    r_op_st <= 1'b0;
                end
                default: r_state <= S_HALT;
            endcase
            // Every state change coincides with a hit or leaves FETCH/DATA, so this also clears on entry.
            r_wait_cnt <= (w_busy & ~w_hit) ? r_wait_cnt + WW'(r_wait_cnt != WW'(TIMEOUT - 1)) : '0;
            if (w_busy & ~w_hit & (r_wait_cnt == WW'(TIMEOUT - 1))) r_timeout <= 1'b1;
            if (w_busy & ~o_pc_en & ~&r_stall) r_stall <= r_stall + 1'b1;
        end
    end
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed vectors with hand-computed expectations for request_unit.
module tb_request_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0, st = 1'b0, hlt = 1'b0, ihit_c = 1'b0, dhit_c = 1'b0;
    logic        imem_ren, dmem_ren, dmem_wen, ihit, dhit, pc_en, halted, timeout;
    logic [31:0] stall;
    int          checks = 0;
    int          failures = 0;

    request_unit #(.TIMEOUT(4), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_load_word_en(ld), .i_store_word_en(st), .i_halt(hlt),
        .i_cache_ihit(ihit_c), .i_cache_dhit(dhit_c),
        .o_imemREN(imem_ren), .o_dmemREN(dmem_ren), .o_dmemWEN(dmem_wen),
        .o_ihit(ihit), .o_dhit(dhit), .o_pc_en(pc_en), .o_halted(halted),
        .o_timeout(timeout), .o_stall_cycles(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {imem_ren, dmem_ren, dmem_wen, ihit, dhit, pc_en, halted, timeout};
    endfunction

    initial begin
        // reset held two cycles, outputs quiet during reset and IDLE
        tick(); tick();
        #1 check("rst_outs", outs(), 8'h00);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        #1 check("idle_outs", outs(), 8'h00);
        tick();
        #1 check("fetch_outs", outs(), 8'h80);
        // back-to-back ALU instructions
        ihit_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check($sformatf("alu_pc_en%0d", i), {ihit, pc_en}, 2'b11);
            tick();
        end
        check("alu_stall", stall, 0);
        // load with three-cycle data wait
        ld = 1'b1;
        #1 check("ld_t", {ihit, pc_en, dmem_ren}, 3'b100);
        tick();
        ld = 1'b0; ihit_c = 1'b0;
        #1 check("ld_t1", outs(), 8'h40);
        tick();
        #1 check("ld_t2", outs(), 8'h40);
        tick();
        dhit_c = 1'b1;
        #1 check("ld_t3", outs(), 8'h4C);
        tick();
        dhit_c = 1'b0;
        #1 check("ld_t4", outs(), 8'h80);
        check("ld_stall", stall, 3);
        // load and store together: load wins
        ld = 1'b1; st = 1'b1; ihit_c = 1'b1;
        #1 check("ldst_fetch", pc_en, 0);
        tick();
        ld = 1'b0; st = 1'b0; ihit_c = 1'b0;
        #1 check("ldst_data", {dmem_ren, dmem_wen}, 2'b10);
        tick();
        dhit_c = 1'b1;
        #1 check("ldst_dhit", {dmem_ren, dmem_wen, pc_en}, 3'b101);
        tick();
        // store only
        dhit_c = 1'b0; st = 1'b1; ihit_c = 1'b1;
        #1 check("st_fetch", pc_en, 0);
        tick();
        st = 1'b0; ihit_c = 1'b0; dhit_c = 1'b1;
        #1 check("st_data", {dmem_ren, dmem_wen, pc_en}, 3'b011);
        tick();
        dhit_c = 1'b0;
        #1 check("st_back", outs(), 8'h80);
        check("mem_stall", stall, 6);
        // halt beats load
        hlt = 1'b1; ld = 1'b1; ihit_c = 1'b1;
        #1 check("halt_fetch", {pc_en, dmem_ren}, 2'b00);
        tick();
        hlt = 1'b0; ld = 1'b0;
        #1 check("halt_outs", outs(), 8'h02);
        tick();
        ihit_c = 1'b0;
        #1 check("halt_stay", outs(), 8'h02);
        check("halt_stall", stall, 7);
        // watchdog with TIMEOUT=4
        rst = 1'b1;
        tick();
        #1 check("rst2_outs", outs(), 8'h00);
        check("rst2_stall", stall, 0);
        rst = 1'b0;
        tick();
        tick(); tick(); tick();
        #1 check("wd_before", {imem_ren, timeout}, 2'b10);
        tick();
        #1 check("wd_set", {imem_ren, timeout}, 2'b11);
        ihit_c = 1'b1;
        #1 check("wd_hit", {pc_en, timeout}, 2'b11);
        tick(); tick();
        #1 check("wd_sticky", {imem_ren, pc_en, timeout}, 3'b111);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
